// File: rtl/mips_boot_loader.sv
// Program/state loader and run controller for the MIPS core: streams words into
// instruction memory or the register file, then runs the core for a bounded budget.
module mips_boot_loader #(
  parameter int DATA_W     = 32,
  parameter int IMEM_AW    = 8,
  parameter int RF_AW      = 5,
  parameter int RUN_CYCLES = 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_valid,
  output logic               o_s_ready,
  input  logic [DATA_W-1:0]  i_s_data,
  input  logic [IMEM_AW-1:0] i_s_addr,
  input  logic               i_s_target,
  input  logic               i_s_last,
  input  logic               i_restart,
  output logic               o_imem_we,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [DATA_W-1:0]  o_imem_wdata,
  output logic               o_rf_we,
  output logic [RF_AW-1:0]   o_rf_addr,
  output logic [DATA_W-1:0]  o_rf_wdata,
  output logic               o_core_reset,
  output logic               o_core_clk_en,
  output logic               o_done,
  output logic               o_err_r0,
  output logic [IMEM_AW:0]   o_word_cnt,
  output logic [31:0]        o_cycle_cnt
);

  typedef enum logic [1:0] {LOAD, RELEASE, RUN, DONE} state_t;

  localparam logic [IMEM_AW:0] WCNT_MAX = '1;
  localparam logic [31:0]      RUN_LAST = 32'(RUN_CYCLES) - 32'd1;

  state_t               r_state;
  logic                 r_s_ready;
  logic                 r_imem_we;
  logic [IMEM_AW-1:0]   r_imem_addr;
  logic [DATA_W-1:0]    r_imem_wdata;
  logic                 r_rf_we;
  logic [RF_AW-1:0]     r_rf_addr;
  logic [DATA_W-1:0]    r_rf_wdata;
  logic                 r_core_reset;
  logic                 r_core_clk_en;
  logic                 r_done;
  logic                 r_err_r0;
  logic [IMEM_AW:0]     r_word_cnt;
  logic [31:0]          r_cycle_cnt;

  logic w_xfer;
  logic w_rf_zero;

  assign w_xfer    = i_s_valid && r_s_ready && (r_state == LOAD);
  assign w_rf_zero = (i_s_addr[RF_AW-1:0] == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= LOAD;
      r_s_ready     <= 1'b1;
      r_imem_we     <= 1'b0;
      r_imem_addr   <= '0;
      r_imem_wdata  <= '0;
      r_rf_we       <= 1'b0;
      r_rf_addr     <= '0;
      r_rf_wdata    <= '0;
      r_core_reset  <= 1'b1;
      r_core_clk_en <= 1'b0;
      r_done        <= 1'b0;
      r_err_r0      <= 1'b0;
      r_word_cnt    <= '0;
      r_cycle_cnt   <= '0;
    end else begin
      // Write strobes are single-cycle pulses; address/data hold their last value.
      r_imem_we <= 1'b0;
      r_rf_we   <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_xfer) begin
            if (!i_s_target) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= i_s_addr;
              r_imem_wdata <= i_s_data;
            end else if (!w_rf_zero) begin
              r_rf_we    <= 1'b1;
              r_rf_addr  <= i_s_addr[RF_AW-1:0];
              r_rf_wdata <= i_s_data;
            end else begin
              r_err_r0 <= 1'b1;
            end
            if (r_word_cnt != WCNT_MAX)
              r_word_cnt <= r_word_cnt + 1'b1;
            if (i_s_last) begin
              r_state   <= RELEASE;
              r_s_ready <= 1'b0;
            end
          end
        end
        RELEASE: begin
          r_state       <= RUN;
          r_core_reset  <= 1'b0;
          r_core_clk_en <= 1'b1;
        end
        RUN: begin
          r_cycle_cnt <= r_cycle_cnt + 32'd1;
          if ((RUN_CYCLES != 0) && (r_cycle_cnt == RUN_LAST)) begin
            r_state       <= DONE;
            r_core_clk_en <= 1'b0;
            r_done        <= 1'b1;
          end
        end
        DONE: begin
          // Core stays out of reset here so its state can be inspected.
          if (i_restart) begin
            r_state      <= LOAD;
            r_s_ready    <= 1'b1;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_word_cnt   <= '0;
            r_cycle_cnt  <= '0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign o_s_ready     = r_s_ready;
  assign o_imem_we     = r_imem_we;
  assign o_imem_addr   = r_imem_addr;
  assign o_imem_wdata  = r_imem_wdata;
  assign o_rf_we       = r_rf_we;
  assign o_rf_addr     = r_rf_addr;
  assign o_rf_wdata    = r_rf_wdata;
  assign o_core_reset  = r_core_reset;
  assign o_core_clk_en = r_core_clk_en;
  assign o_done        = r_done;
  assign o_err_r0      = r_err_r0;
  assign o_word_cnt    = r_word_cnt;
  assign o_cycle_cnt   = r_cycle_cnt;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Scoreboard bench for mips_boot_loader: one instance with a 10-cycle budget,
// one with an unlimited budget for the free-running and saturation cases.
module tb_mips_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Budgeted instance
  logic        s_valid, s_ready, s_target, s_last, restart;
  logic [31:0] s_data;
  logic [7:0]  s_addr;
  logic        imem_we, rf_we, core_reset, core_clk_en, done, err_r0;
  logic [7:0]  imem_addr;
  logic [4:0]  rf_addr;
  logic [31:0] imem_wdata, rf_wdata, cycle_cnt;
  logic [8:0]  word_cnt;

  // Unlimited-budget instance
  logic        s_valid_z, s_ready_z, s_target_z, s_last_z, restart_z;
  logic [31:0] s_data_z;
  logic [7:0]  s_addr_z;
  logic        imem_we_z, rf_we_z, core_reset_z, core_clk_en_z, done_z, err_r0_z;
  logic [7:0]  imem_addr_z;
  logic [4:0]  rf_addr_z;
  logic [31:0] imem_wdata_z, rf_wdata_z, cycle_cnt_z;
  logic [8:0]  word_cnt_z;

  mips_boot_loader #(.DATA_W(32), .IMEM_AW(8), .RF_AW(5), .RUN_CYCLES(10)) dut (
    .i_clk(clk), .i_reset(rst), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .i_s_data(s_data), .i_s_addr(s_addr), .i_s_target(s_target), .i_s_last(s_last),
    .i_restart(restart), .o_imem_we(imem_we), .o_imem_addr(imem_addr),
    .o_imem_wdata(imem_wdata), .o_rf_we(rf_we), .o_rf_addr(rf_addr),
    .o_rf_wdata(rf_wdata), .o_core_reset(core_reset), .o_core_clk_en(core_clk_en),
    .o_done(done), .o_err_r0(err_r0), .o_word_cnt(word_cnt), .o_cycle_cnt(cycle_cnt)
  );

  mips_boot_loader #(.DATA_W(32), .IMEM_AW(8), .RF_AW(5), .RUN_CYCLES(0)) dut_z (
    .i_clk(clk), .i_reset(rst), .i_s_valid(s_valid_z), .o_s_ready(s_ready_z),
    .i_s_data(s_data_z), .i_s_addr(s_addr_z), .i_s_target(s_target_z), .i_s_last(s_last_z),
    .i_restart(restart_z), .o_imem_we(imem_we_z), .o_imem_addr(imem_addr_z),
    .o_imem_wdata(imem_wdata_z), .o_rf_we(rf_we_z), .o_rf_addr(rf_addr_z),
    .o_rf_wdata(rf_wdata_z), .o_core_reset(core_reset_z), .o_core_clk_en(core_clk_en_z),
    .o_done(done_z), .o_err_r0(err_r0_z), .o_word_cnt(word_cnt_z), .o_cycle_cnt(cycle_cnt_z)
  );

  typedef struct packed {
    logic        tgt;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  n_we_z = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (imem_we || rf_we) begin
      check("sb_has_entry", 64'(sb.size() != 0), 64'(1));
      check("we_single", 64'(imem_we && rf_we), 64'(0));
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        $display("write tgt=%0d addr=%0h data=%0h cyc=%0d", rf_we, rf_we ? {3'b0, rf_addr} : imem_addr,
                 rf_we ? rf_wdata : imem_wdata, cyc);
        check("we_target", 64'(rf_we), 64'(mon_e.tgt));
        check("we_addr", 64'(rf_we ? {3'b0, rf_addr} : imem_addr), 64'(mon_e.addr));
        check("we_data", 64'(rf_we ? rf_wdata : imem_wdata), 64'(mon_e.data));
        check("we_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    if (imem_we_z) n_we_z <= n_we_z + 1;
  end

  task automatic send(input logic tgt, input logic [7:0] addr, input logic [31:0] data, input logic last);
    wr_t e;
    s_valid = 1'b1; s_target = tgt; s_addr = addr; s_data = data; s_last = last;
    if (s_ready && !(tgt && addr[4:0] == 5'd0)) begin
      e.tgt = tgt; e.addr = tgt ? {3'b0, addr[4:0]} : addr; e.data = data; e.cyc = 32'(cyc + 1);
      sb.push_back(e);
    end
    $display("send tgt=%0d addr=%0h data=%0h last=%0d ready=%0d", tgt, addr, data, last, s_ready);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle_load();
    check("ready_idle", 64'(s_ready), 64'(1));
    @(negedge clk);
  endtask

  task automatic wait_done(input int exp_en);
    int en;
    bit seen;
    en = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (core_clk_en) en++;
    end
    check("done_seen", 64'(seen), 64'(1));
    check("enabled_cycles", 64'(en), 64'(exp_en));
    check("done_cycle_cnt", 64'(cycle_cnt), 64'(10));
    check("done_clk_en", 64'(core_clk_en), 64'(0));
    check("done_core_reset", 64'(core_reset), 64'(0));
    check("done_ready", 64'(s_ready), 64'(0));
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_ready", 64'(s_ready), 64'(1));
    check("rs_done", 64'(done), 64'(0));
    check("rs_core_reset", 64'(core_reset), 64'(1));
    check("rs_word_cnt", 64'(word_cnt), 64'(0));
    check("rs_cycle_cnt", 64'(cycle_cnt), 64'(0));
  endtask

  initial begin
    int en_z;
    bit done_z_seen;
    bit hit;
    rst = 1'b1;
    s_valid = 0; s_target = 0; s_last = 0; restart = 0; s_data = '0; s_addr = '0;
    s_valid_z = 0; s_target_z = 0; s_last_z = 0; restart_z = 0; s_data_z = '0; s_addr_z = '0;
    #1;
    check("rst_ready", 64'(s_ready), 64'(1));
    check("rst_core_reset", 64'(core_reset), 64'(1));
    check("rst_clk_en", 64'(core_clk_en), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err_r0", 64'(err_r0), 64'(0));
    check("rst_word_cnt", 64'(word_cnt), 64'(0));
    check("rst_cycle_cnt", 64'(cycle_cnt), 64'(0));
    check("rst_strobes", 64'({imem_we, rf_we}), 64'(0));
    check("rst_imem_addr", 64'(imem_addr), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Image 1: 11 imem words back-to-back, then rf[8]=1, rf[9]=0 (last)
    for (int i = 0; i < 11; i++) send(1'b0, 8'(i), 32'h21080001, 1'b0);
    send(1'b1, 8'd8, 32'd1, 1'b0);
    send(1'b1, 8'd9, 32'd0, 1'b1);
    check("rel_ready", 64'(s_ready), 64'(0));
    check("rel_core_reset", 64'(core_reset), 64'(1));
    s_valid = 1'b1; s_target = 1'b0; s_addr = 8'h63; s_data = 32'hdeadbeef;
    @(negedge clk);
    s_valid = 1'b0;
    check("run_core_reset", 64'(core_reset), 64'(0));
    check("run_clk_en", 64'(core_clk_en), 64'(1));
    check("img1_word_cnt", 64'(word_cnt), 64'(13));
    wait_done(9);

    // Image 2: toggling valid, includes a dropped r0 write
    do_restart();
    send(1'b0, 8'd30, 32'h11110000, 1'b0); idle_load();
    send(1'b1, 8'd0, 32'h5, 1'b0);         idle_load();
    check("err_r0_set", 64'(err_r0), 64'(1));
    send(1'b1, 8'd3, 32'h33330000, 1'b0);  idle_load();
    send(1'b0, 8'd31, 32'h44440000, 1'b0); idle_load();
    send(1'b1, 8'd4, 32'h55550000, 1'b1);
    @(negedge clk);
    check("img2_word_cnt", 64'(word_cnt), 64'(5));
    check("err_r0_run", 64'(err_r0), 64'(1));
    wait_done(9);
    check("err_r0_done", 64'(err_r0), 64'(1));

    // Image 3: asynchronous reset in RUN at cycle_cnt == 3
    do_restart();
    send(1'b0, 8'd40, 32'hcafe0001, 1'b0);
    send(1'b1, 8'd7, 32'hcafe0002, 1'b1);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (cycle_cnt == 32'd3 && core_clk_en) hit = 1;
    end
    check("reach_cnt3", 64'(hit), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_core_reset", 64'(core_reset), 64'(1));
    check("arst_clk_en", 64'(core_clk_en), 64'(0));
    check("arst_cycle_cnt", 64'(cycle_cnt), 64'(0));
    check("arst_ready", 64'(s_ready), 64'(1));
    check("arst_err_r0", 64'(err_r0), 64'(0));
    #1 rst = 1'b0;
    @(negedge clk);
    send(1'b0, 8'd50, 32'hbeef0001, 1'b0);
    send(1'b1, 8'd1, 32'hbeef0002, 1'b1);
    wait_done(10);
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));

    // Unlimited budget: 515 words saturate word_cnt, then 100 free-running cycles
    for (int i = 0; i < 515; i++) begin
      s_valid_z = 1'b1; s_target_z = 1'b0; s_addr_z = 8'(i); s_data_z = 32'(i);
      s_last_z = (i == 514);
      @(negedge clk);
    end
    s_valid_z = 1'b0; s_last_z = 1'b0;
    check("z_word_cnt_sat", 64'(word_cnt_z), 64'(511));
    en_z = 0; done_z_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_clk_en_z) en_z++;
      if (done_z) done_z_seen = 1;
    end
    @(negedge clk);
    $display("unlimited run: en=%0d cycle_cnt=%0d pulses=%0d", en_z, cycle_cnt_z, n_we_z);
    check("z_we_pulses", 64'(n_we_z), 64'(515));
    check("z_enabled", 64'(en_z), 64'(100));
    check("z_done", 64'(done_z_seen), 64'(0));
    check("z_cycle_cnt", 64'(cycle_cnt_z), 64'(100));
    check("z_clk_en", 64'(core_clk_en_z), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
- Parametrised program/state loader and run controller for the MIPS core.
- Accepts a valid/ready word stream and writes each word into instruction memory or the register file.
- Holds the core in reset while loading, then releases it for a bounded number of cycles.
- Freezes the core when the budget expires and reports completion.
- Sits between the bench or host link and the core's instruction memory and register-file write ports.

Parameters:
- DATA_W, 32, word width of the stream and of both memories.
- IMEM_AW, 8, instruction memory address width; depth is 2^IMEM_AW words.
- RF_AW, 5, register file address width.
- RUN_CYCLES, 20, core clock-enable budget in cycles; 0 means unlimited.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader accepts a word this cycle.
- s_data  in  DATA_W  word to write.
- s_addr  in  IMEM_AW  target address; for the register file only the low RF_AW bits are used.
- s_target  in  1  0 = instruction memory, 1 = register file.
- s_last  in  1  final word of the load image.
- restart  in  1  single-cycle pulse; in DONE, begins a new load.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  IMEM_AW  instruction memory write address.
- imem_wdata  out  DATA_W  instruction memory write data.
- rf_we  out  1  register file write strobe.
- rf_addr  out  RF_AW  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- core_reset  out  1  active-high reset to the core.
- core_clk_en  out  1  core clock enable.
- done  out  1  run budget exhausted.
- err_r0  out  1  sticky flag: a write to register 0 was attempted.
- word_cnt  out  IMEM_AW+1  accepted words, saturating.
- cycle_cnt  out  32  core-enabled cycles in the current run.

Behaviour:
- States: LOAD, RELEASE, RUN, DONE.
- Reset (asynchronous):
  - state = LOAD.
  - s_ready = 1, core_reset = 1.
  - core_clk_en = 0, done = 0, err_r0 = 0.
  - imem_we = 0, rf_we = 0; all address and data outputs = 0.
  - word_cnt = 0, cycle_cnt = 0.
- All outputs are registered.
- LOAD:
  - s_ready = 1. A transfer occurs when s_valid && s_ready.
  - Write latency is one cycle: the strobe, address and data appear on the cycle after the transfer, for exactly one cycle.
  - s_target = 0: drive imem_we.
  - s_target = 1 with rf address != 0: drive rf_we.
  - s_target = 1 with rf address == 0: no write strobe; err_r0 sets to 1 and stays set.
  - Every transfer increments word_cnt, including dropped r0 writes. word_cnt saturates at 2^(IMEM_AW+1)-1.
  - A later write to the same address overwrites the earlier one; no checking is performed.
  - A transfer with s_last = 1 moves to RELEASE.
- RELEASE, one cycle:
  - s_ready = 0, core_reset = 1.
  - The last word's write strobe is issued in this cycle.
  - Next state RUN.
- RUN:
  - core_reset = 0, core_clk_en = 1, s_ready = 0; s_valid is ignored.
  - cycle_cnt increments each cycle.
  - If RUN_CYCLES != 0 and cycle_cnt == RUN_CYCLES-1, go to DONE; cycle_cnt ends equal to RUN_CYCLES.
  - If RUN_CYCLES == 0, remain in RUN until reset. cycle_cnt wraps modulo 2^32.
- DONE:
  - core_clk_en = 0, core_reset = 0 (core state preserved for inspection), done = 1, s_ready = 0.
  - restart = 1 goes to LOAD and clears word_cnt, cycle_cnt and done; it reasserts core_reset on the next cycle.
  - err_r0 is cleared only by reset.
- restart in LOAD, RELEASE or RUN is ignored.
- Reset mid-operation:
  - Any in-flight write strobe is dropped immediately; the outputs go to 0 asynchronously.
  - The load restarts from LOAD with no partial state.
- A word with s_last = 1 accepted while s_valid stays high: the next word is not accepted (s_ready = 0 in RELEASE).

Test Plan:
- Load 11 words 0x21080001 to imem 0..10, then rf[8]=1 and rf[9]=0 with s_last on the final word, RUN_CYCLES=10 → 11 imem_we pulses at addresses 0..10 and rf_we at 8 and 9. word_cnt=13; core_reset falls 2 cycles after the last transfer. done rises after 10 enabled cycles with cycle_cnt=10.
- Stream includes rf address 0 data 0x5 → no rf_we; err_r0=1 and remains 1 through RUN and DONE; word_cnt counts the word.
- s_valid toggling 1-0-1 each cycle for 4 words → exactly 4 write pulses, each one cycle after its transfer; s_ready stays 1 until s_last.
- Assert reset in RUN at cycle_cnt=3 → core_reset=1, core_clk_en=0, cycle_cnt=0 and state LOAD asynchronously; reload → normal run.
- In DONE pulse restart → s_ready=1 next cycle, done=0, core_reset=1; a second image loads and runs to done again.
- RUN_CYCLES=0 parameter run for 100 cycles → done stays 0, cycle_cnt=100, core_clk_en stays 1.
